// File: rtl/pixel_sink_pkg.sv
// pixel_sink_pkg
//  Shared types and helpers for the pixel frame sink.
//  - state_t   : capture FSM states
//  - coord_t   : signed incoming coordinate
//  - in_bounds : signed bounds test of a coordinate pair against the frame size
package pixel_sink_pkg;

  localparam int COORD_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef logic signed [COORD_W_DEF-1:0] coord_t;

  // Signed compare on the full coordinate width, so negative values clip
  // instead of aliasing into the frame through their low bits.
  function automatic logic in_bounds(input coord_t x, input coord_t y,
                                     input int fb_w, input int fb_h);
    return (x >= 0) && (x < fb_w) && (y >= 0) && (y < fb_h);
  endfunction

endpackage

// File: rtl/pixel_bitmap.sv
// pixel_bitmap
//  FB_W x FB_H single-bit frame held in flops, addressed as {y, x}.
//  Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears every bit)
//   clear       clears every bit on the next edge (wins over set_en)
//   set_en      sets bits[set_addr] on the next edge
//   set_addr    write address
//   set_hit     combinational: bits[set_addr] is already 1
//   rd_addr     read address
//   rd_pixel    registered bits[rd_addr]; a same-edge write is not yet visible
module pixel_bitmap #(
  parameter  int FB_W = 16,
  parameter  int FB_H = 16,
  localparam int AW   = $clog2(FB_W * FB_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  output logic          set_hit,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_pixel
);

  logic [FB_W*FB_H-1:0] bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
    end else if (clear) begin
      bits <= '0;
    end else if (set_en) begin
      bits[set_addr] <= 1'b1;
    end
  end

  // Samples the pre-edge array, which gives read-before-write for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pixel <= 1'b0;
    end else begin
      rd_pixel <= bits[rd_addr];
    end
  end

  assign set_hit = bits[set_addr];

endmodule

// File: rtl/pixel_frame_sink.sv
// pixel_frame_sink
//  Rasterises a stream of signed (x,y) coordinates into an FB_W x FB_H bitmap and
//  keeps unique / duplicate / clipped counts plus a bounding box.
//  Handshake: _valid is a one-way strobe with no ready; a beat presented while
//  capturing is consumed in that same cycle, beats in IDLE/DONE are dropped.
//  Ports:
//   _clock, _reset_n         clock, asynchronous active-low reset
//   _start                   clear frame and stats, enter CAPTURE
//   _in0/_in1/_valid         signed x / y pixel strobe
//   _in_done                 end of shape: CAPTURE -> DONE
//   _rd_x/_rd_y/_rd_pixel    registered read port, 1-cycle latency
//   _busy/_frame_done        in CAPTURE / in DONE
//   _pixel_count/_dup_count/_clip_count  saturating statistics
//   _bbox_valid/_min_*/_max_*            bounding box of in-bounds pixels
//   _state                   current FSM state (debug)
module pixel_frame_sink
  import pixel_sink_pkg::*;
#(
  parameter  int COORD_W = COORD_W_DEF,
  parameter  int FB_W    = 16,
  parameter  int FB_H    = 16,
  parameter  int CNT_W   = 16,
  localparam int XW      = $clog2(FB_W),
  localparam int YW      = $clog2(FB_H)
) (
  input  logic                      _clock,
  input  logic                      _reset_n,
  input  logic                      _start,
  input  logic signed [COORD_W-1:0] _in0,
  input  logic signed [COORD_W-1:0] _in1,
  input  logic                      _valid,
  input  logic                      _in_done,
  input  logic [XW-1:0]             _rd_x,
  input  logic [YW-1:0]             _rd_y,
  output logic                      _rd_pixel,
  output logic                      _busy,
  output logic                      _frame_done,
  output logic [CNT_W-1:0]          _pixel_count,
  output logic [CNT_W-1:0]          _dup_count,
  output logic [CNT_W-1:0]          _clip_count,
  output logic                      _bbox_valid,
  output logic [XW-1:0]             _min_x,
  output logic [XW-1:0]             _max_x,
  output logic [YW-1:0]             _min_y,
  output logic [YW-1:0]             _max_y,
  output state_t                    _state
);

  state_t state_q, state_d;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // _start is checked first so it beats a coincident _in_done.
  always_comb begin
    state_d = state_q;
    if (_start) begin
      state_d = CAPTURE;
    end else begin
      case (state_q)
        CAPTURE: if (_in_done) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    _busy       = (state_q == CAPTURE);
    _frame_done = (state_q == DONE);
    _state      = state_q;
  end

  // ---------------- pixel classification ----------------
  logic          pix_take;
  logic          pix_inb;
  logic          pix_clip;
  logic          pix_hit;
  logic [XW-1:0] px;
  logic [YW-1:0] py;

  assign px       = _in0[XW-1:0];
  assign py       = _in1[YW-1:0];
  // A pixel in the _start cycle is discarded along with the old frame.
  assign pix_take = _valid && (state_q == CAPTURE) && !_start;
  assign pix_inb  = pix_take && in_bounds(coord_t'(_in0), coord_t'(_in1), FB_W, FB_H);
  assign pix_clip = pix_take && !pix_inb;

  pixel_bitmap #(
    .FB_W (FB_W),
    .FB_H (FB_H)
  ) u_bitmap (
    .clk      (_clock),
    .rst_n    (_reset_n),
    .clear    (_start),
    .set_en   (pix_inb),
    .set_addr ({py, px}),
    .set_hit  (pix_hit),
    .rd_addr  ({_rd_y, _rd_x}),
    .rd_pixel (_rd_pixel)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // ---------------- statistics ----------------
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      _pixel_count <= '0;
      _dup_count   <= '0;
      _clip_count  <= '0;
    end else if (_start) begin
      _pixel_count <= '0;
      _dup_count   <= '0;
      _clip_count  <= '0;
    end else begin
      if (pix_inb && !pix_hit) _pixel_count <= sat_inc(_pixel_count);
      if (pix_inb && pix_hit)  _dup_count   <= sat_inc(_dup_count);
      if (pix_clip)            _clip_count  <= sat_inc(_clip_count);
    end
  end

  // ---------------- bounding box ----------------
  // Duplicates also update the box; they cannot widen it, so no special case.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      _bbox_valid <= 1'b0;
      _min_x      <= '0;
      _max_x      <= '0;
      _min_y      <= '0;
      _max_y      <= '0;
    end else if (_start) begin
      _bbox_valid <= 1'b0;
      _min_x      <= '0;
      _max_x      <= '0;
      _min_y      <= '0;
      _max_y      <= '0;
    end else if (pix_inb) begin
      _bbox_valid <= 1'b1;
      if (!_bbox_valid) begin
        _min_x <= px;
        _max_x <= px;
        _min_y <= py;
        _max_y <= py;
      end else begin
        if (px < _min_x) _min_x <= px;
        if (px > _max_x) _max_x <= px;
        if (py < _min_y) _min_y <= py;
        if (py > _max_y) _max_y <= py;
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_sink.sv
// tb_pixel_frame_sink
//  Directed bench for pixel_frame_sink: reset, counting, clipping, start/done
//  priority, full-frame fill, rectangle outline, read-port scans. A second
//  instance with 3-bit counters shares the stimulus to exercise saturation.
module tb_pixel_frame_sink;
  import pixel_sink_pkg::*;

  localparam int FB_W = 16;
  localparam int FB_H = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic signed [31:0] in0 = '0;
  logic signed [31:0] in1 = '0;
  logic               valid = 1'b0;
  logic               in_done = 1'b0;
  logic [3:0]         rd_x = '0;
  logic [3:0]         rd_y = '0;

  logic        rd_pixel, busy, frame_done, bbox_valid;
  logic [15:0] pixel_count, dup_count, clip_count;
  logic [3:0]  min_x, max_x, min_y, max_y;
  state_t      state;

  logic        s_rd_pixel, s_busy, s_frame_done, s_bbox_valid;
  logic [2:0]  s_pixel_count, s_dup_count, s_clip_count;
  logic [3:0]  s_min_x, s_max_x, s_min_y, s_max_y;
  state_t      s_state;

  pixel_frame_sink dut (
    ._clock(clk), ._reset_n(rst_n), ._start(start), ._in0(in0), ._in1(in1),
    ._valid(valid), ._in_done(in_done), ._rd_x(rd_x), ._rd_y(rd_y),
    ._rd_pixel(rd_pixel), ._busy(busy), ._frame_done(frame_done),
    ._pixel_count(pixel_count), ._dup_count(dup_count), ._clip_count(clip_count),
    ._bbox_valid(bbox_valid), ._min_x(min_x), ._max_x(max_x),
    ._min_y(min_y), ._max_y(max_y), ._state(state)
  );

  pixel_frame_sink #(.CNT_W(3)) sat_dut (
    ._clock(clk), ._reset_n(rst_n), ._start(start), ._in0(in0), ._in1(in1),
    ._valid(valid), ._in_done(in_done), ._rd_x(rd_x), ._rd_y(rd_y),
    ._rd_pixel(s_rd_pixel), ._busy(s_busy), ._frame_done(s_frame_done),
    ._pixel_count(s_pixel_count), ._dup_count(s_dup_count), ._clip_count(s_clip_count),
    ._bbox_valid(s_bbox_valid), ._min_x(s_min_x), ._max_x(s_max_x),
    ._min_y(s_min_y), ._max_y(s_max_y), ._state(s_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  logic       golden [FB_H][FB_W];
  int         model_count, model_dup;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input int x, input int y);
    in0 = x; in1 = y; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic send_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_done();
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
  endtask

  task automatic read_pix(input int x, input int y, output logic v);
    rd_x = 4'(x); rd_y = 4'(y);
    tick();
    v = rd_pixel;
  endtask

  task automatic check_stats(input string tag, input int c, input int d, input int k);
    check_eq({tag, "_count"}, 32'(pixel_count), 32'(c));
    check_eq({tag, "_dup"},   32'(dup_count),   32'(d));
    check_eq({tag, "_clip"},  32'(clip_count),  32'(k));
  endtask

  task automatic check_bbox(input string tag, input int x0, input int x1, input int y0, input int y1);
    check_eq({tag, "_bbv"},  32'(bbox_valid), 32'd1);
    check_eq({tag, "_minx"}, 32'(min_x), 32'(x0));
    check_eq({tag, "_maxx"}, 32'(max_x), 32'(x1));
    check_eq({tag, "_miny"}, 32'(min_y), 32'(y0));
    check_eq({tag, "_maxy"}, 32'(max_y), 32'(y1));
  endtask

  task automatic scan_all(input string tag, input logic v_exp);
    logic v;
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++) begin
        read_pix(x, y, v);
        check_eq(tag, 32'(v), 32'(v_exp));
      end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic v;
    int   pts_x[$];
    int   pts_y[$];

    // reset state
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_state", 32'(state), 32'(IDLE));
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(frame_done), 32'd0);
    check_eq("rst_bbv",   32'(bbox_valid), 32'd0);
    check_eq("rst_rd",    32'(rd_pixel), 32'd0);
    check_stats("rst", 0, 0, 0);

    // pixel in IDLE is ignored
    send_pixel(2, 2);
    check_stats("idle_ign", 0, 0, 0);

    // test 1: reset in the middle of a capture
    send_start();
    check_eq("t1_capture", 32'(state), 32'(CAPTURE));
    for (int i = 0; i < 5; i++) send_pixel(i, i);
    check_stats("t1_pre", 5, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t1_async_state", 32'(state), 32'(IDLE));
    check_eq("t1_async_busy",  32'(busy), 32'd0);
    check_eq("t1_async_bbv",   32'(bbox_valid), 32'd0);
    check_stats("t1_async", 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    scan_all("t1_scan", 1'b0);

    // test 2: basic shape, read-before-write, done latency
    send_start();
    rd_x = 4'd1; rd_y = 4'd2;
    send_pixel(1, 2);
    check_eq("t2_rbw_old", 32'(rd_pixel), 32'd0);
    send_pixel(2, 2);
    check_eq("t2_rbw_new", 32'(rd_pixel), 32'd1);
    send_pixel(4, 4);
    check_eq("t2_done_pre", 32'(frame_done), 32'd0);
    send_done();
    check_eq("t2_done", 32'(frame_done), 32'd1);
    check_eq("t2_busy", 32'(busy), 32'd0);
    check_stats("t2", 3, 0, 0);
    check_bbox("t2", 1, 4, 2, 4);

    // test 3: duplicates and clipping, last pixel together with done
    send_start();
    send_pixel(3, 3);
    send_pixel(3, 3);
    send_pixel(-1, 0);
    send_pixel(16, 5);
    in0 = 0; in1 = 16; valid = 1'b1; in_done = 1'b1;
    tick();
    valid = 1'b0; in_done = 1'b0;
    check_eq("t3_done", 32'(frame_done), 32'd1);
    check_stats("t3", 1, 1, 3);
    check_bbox("t3", 3, 3, 3, 3);
    send_pixel(5, 5);
    check_stats("t3_done_ign", 1, 1, 3);
    read_pix(5, 5, v);
    check_eq("t3_done_nowr", 32'(v), 32'd0);

    // test 4: start and done together in DONE; start wins, pixel discarded
    start = 1'b1; in_done = 1'b1; valid = 1'b1; in0 = 7; in1 = 7;
    tick();
    start = 1'b0; in_done = 1'b0; valid = 1'b0;
    check_eq("t4_state", 32'(state), 32'(CAPTURE));
    check_eq("t4_done",  32'(frame_done), 32'd0);
    check_eq("t4_bbv",   32'(bbox_valid), 32'd0);
    check_stats("t4", 0, 0, 0);
    read_pix(7, 7, v);
    check_eq("t4_discard", 32'(v), 32'd0);
    read_pix(3, 3, v);
    check_eq("t4_cleared", 32'(v), 32'd0);

    // test 5: fill the whole frame, then one duplicate
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++) send_pixel(x, y);
    send_pixel(0, 0);
    check_stats("t5", 256, 1, 0);
    check_bbox("t5", 0, 15, 0, 15);
    check_eq("t5_sat_count", 32'(s_pixel_count), 32'd7);
    check_eq("t5_sat_dup",   32'(s_dup_count), 32'd1);
    send_done();
    scan_all("t5_scan", 1'b1);

    // test 6: rectangle outline s_x=1 s_y=2 height=3 width=4, corners repeat
    send_start();
    for (int i = 0; i <= 4; i++) begin pts_x.push_back(1 + i); pts_y.push_back(2); end
    for (int j = 0; j <= 3; j++) begin pts_x.push_back(5);     pts_y.push_back(2 + j); end
    for (int i = 0; i <= 4; i++) begin pts_x.push_back(5 - i); pts_y.push_back(5); end
    for (int j = 0; j <= 3; j++) begin pts_x.push_back(1);     pts_y.push_back(5 - j); end
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++) golden[y][x] = 1'b0;
    model_count = 0;
    model_dup   = 0;
    for (int i = 0; i < pts_x.size(); i++) begin
      if (golden[pts_y[i]][pts_x[i]]) model_dup++;
      else begin golden[pts_y[i]][pts_x[i]] = 1'b1; model_count++; end
      send_pixel(pts_x[i], pts_y[i]);
    end
    send_done();
    check_eq("t6_model_count", 32'(model_count), 32'd14);
    check_stats("t6", model_count, model_dup, 0);
    check_bbox("t6", 1, 5, 2, 5);
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++) exp_q.push_back(golden[y][x]);
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++) begin
        logic [0:0] e;
        read_pix(x, y, v);
        e = exp_q.pop_front();
        check_eq("t6_scan", 32'(v), 32'(e));
      end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
